// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - time-multiplexes one waveform generator across oscillator voices and mixes one sample per frame
module voice_scheduler #(
    parameter int NUM_VOICES  = 32,
    parameter int ACC_WIDTH   = 24,
    parameter int GEN_LATENCY = 3,
    parameter int MIX_SHIFT   = 3
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_SampleTick,
    input  logic                          i_ConfigWrite,
    input  logic [$clog2(NUM_VOICES)-1:0] i_ConfigVoice,
    input  logic [ACC_WIDTH-1:0]          i_ConfigIncrement,
    input  logic                          i_ConfigWaveform,
    input  logic                          i_ConfigEnable,
    input  logic                          i_ConfigPhaseReset,
    output logic [12:0]                   o_Phase,
    output logic                          o_Waveform,
    input  logic [15:0]                   i_Amplitude,
    output logic [15:0]                   o_Sample,
    output logic                          o_SampleValid,
    output logic                          o_Busy,
    output logic                          o_Overrun
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam int SW = 16 + VW;
    localparam int TD = GEN_LATENCY + 1;
    localparam int DW = (GEN_LATENCY > 1) ? $clog2(GEN_LATENCY) : 1;
    localparam logic signed [SW-1:0] SAT_MAX = 32767;
    localparam logic signed [SW-1:0] SAT_MIN = -32768;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [VW-1:0]         voice_q, voice_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic [ACC_WIDTH-1:0]  acc_q [NUM_VOICES];
    logic [ACC_WIDTH-1:0]  acc_d [NUM_VOICES];
    logic [ACC_WIDTH-1:0]  inc_q [NUM_VOICES];
    logic [ACC_WIDTH-1:0]  inc_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_q, en_d;
    logic [NUM_VOICES-1:0] wave_q, wave_d;
    logic [TD-1:0]         tag_q, tag_d;
    logic signed [SW-1:0]  sum_q, sum_d;
    logic signed [SW-1:0]  amp_ext;
    logic signed [SW-1:0]  shifted;
    logic [12:0]           phase_q, phase_d;
    logic                  wave_out_q, wave_out_d;
    logic [15:0]           sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    assign amp_ext       = {{VW{i_Amplitude[15]}}, i_Amplitude};
    assign o_Phase       = phase_q;
    assign o_Waveform    = wave_out_q;
    assign o_Sample      = sample_q;
    assign o_SampleValid = valid_q;
    assign o_Busy        = (state_q != S_IDLE);
    assign o_Overrun     = overrun_q;

    always_comb begin
        state_d    = state_q;
        voice_d    = voice_q;
        drain_d    = drain_q;
        acc_d      = acc_q;
        inc_d      = inc_q;
        en_d       = en_q;
        wave_d     = wave_q;
        tag_d      = {tag_q[TD-2:0], 1'b0};
        sum_d      = sum_q;
        phase_d    = phase_q;
        wave_out_d = wave_out_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        overrun_d  = overrun_q;

        // The tag leaving the pipeline lines up with this cycle's generator output.
        if (tag_q[TD-1]) begin
            sum_d = sum_q + amp_ext;
        end
        shifted = sum_d >>> MIX_SHIFT;

        case (state_q)
            S_IDLE: begin
                if (i_SampleTick) begin
                    state_d = S_ISSUE;
                    voice_d = '0;
                    sum_d   = '0;
                end
            end
            S_ISSUE: begin
                phase_d    = acc_q[voice_q][ACC_WIDTH-1 -: 13];
                wave_out_d = wave_q[voice_q];
                tag_d[0]   = en_q[voice_q];
                if (en_q[voice_q]) begin
                    acc_d[voice_q] = acc_q[voice_q] + inc_q[voice_q];
                end
                if (voice_q == VW'(NUM_VOICES - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    voice_d = voice_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(GEN_LATENCY - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                if (shifted > SAT_MAX) begin
                    sample_d = 16'h7FFF;
                end else if (shifted < SAT_MIN) begin
                    sample_d = 16'h8000;
                end else begin
                    sample_d = shifted[15:0];
                end
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (i_SampleTick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        // Applied last so a phase reset beats a same-cycle accumulator advance.
        if (i_ConfigWrite) begin
            inc_d[i_ConfigVoice]  = i_ConfigIncrement;
            en_d[i_ConfigVoice]   = i_ConfigEnable;
            wave_d[i_ConfigVoice] = i_ConfigWaveform;
            if (i_ConfigPhaseReset) begin
                acc_d[i_ConfigVoice] = '0;
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= S_IDLE;
            voice_q    <= '0;
            drain_q    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= '0;
            end
            en_q       <= '0;
            wave_q     <= '0;
            tag_q      <= '0;
            sum_q      <= '0;
            phase_q    <= '0;
            wave_out_q <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            voice_q    <= voice_d;
            drain_q    <= drain_d;
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            en_q       <= en_d;
            wave_q     <= wave_d;
            tag_q      <= tag_d;
            sum_q      <= sum_d;
            phase_q    <= phase_d;
            wave_out_q <= wave_out_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - self-checking bench for voice_scheduler
`timescale 1ns/1ps
module tb_voice_scheduler;

    localparam int NV = 32;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_SampleTick = 1'b0;
    logic        i_ConfigWrite = 1'b0;
    logic [4:0]  i_ConfigVoice = '0;
    logic [23:0] i_ConfigIncrement = '0;
    logic        i_ConfigWaveform = 1'b0;
    logic        i_ConfigEnable = 1'b0;
    logic        i_ConfigPhaseReset = 1'b0;
    logic [12:0] o_Phase;
    logic        o_Waveform;
    logic [15:0] i_Amplitude = '0;
    logic [15:0] o_Sample;
    logic        o_SampleValid;
    logic        o_Busy;
    logic        o_Overrun;

    int vectors = 0;
    int errors  = 0;

    always #5 i_Clock = ~i_Clock;

    voice_scheduler dut (
        .i_Clock            (i_Clock),
        .i_Reset            (i_Reset),
        .i_SampleTick       (i_SampleTick),
        .i_ConfigWrite      (i_ConfigWrite),
        .i_ConfigVoice      (i_ConfigVoice),
        .i_ConfigIncrement  (i_ConfigIncrement),
        .i_ConfigWaveform   (i_ConfigWaveform),
        .i_ConfigEnable     (i_ConfigEnable),
        .i_ConfigPhaseReset (i_ConfigPhaseReset),
        .o_Phase            (o_Phase),
        .o_Waveform         (o_Waveform),
        .i_Amplitude        (i_Amplitude),
        .o_Sample           (o_Sample),
        .o_SampleValid      (o_SampleValid),
        .o_Busy             (o_Busy),
        .o_Overrun          (o_Overrun)
    );

    // Generator stand-in: square is full scale by phase MSB, "sine" is a ramp 8*phase+5.
    function automatic logic [15:0] gen_amp(input logic [12:0] ph, input logic wv);
        if (wv) return ph[12] ? 16'h8000 : 16'h7FFF;
        return {ph, 3'b101};
    endfunction

    logic [15:0] g1 = '0;
    logic [15:0] g2 = '0;
    always @(posedge i_Clock) begin
        g1          <= gen_amp(o_Phase, o_Waveform);
        g2          <= g1;
        i_Amplitude <= g2;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Frame-level model: a frame starts on an accepted tick at cycle n0, voice v shows
    // on o_Phase at n0+2+v, busy covers n0+1..n0+36, the new sample appears at n0+37.
    logic [23:0] m_acc [NV];
    logic [23:0] m_inc [NV];
    logic        m_en  [NV];
    logic        m_wave[NV];
    logic [12:0] f_ph  [NV];
    logic        f_wv  [NV];
    int          cyc = 0;
    int          n0 = 0;
    bit          act = 0;
    bit          vdue = 0;
    int          vcyc = 0;
    logic [15:0] vsample = '0;
    logic [12:0] e_phase = '0;
    logic        e_wave = 1'b0;
    logic [15:0] e_sample = '0;
    logic        e_overrun = 1'b0;

    always @(negedge i_Clock) begin
        bit     busy;
        bit     vld;
        longint sum;
        cyc++;
        if (i_Reset) begin
            for (int i = 0; i < NV; i++) begin
                m_acc[i] = '0; m_inc[i] = '0; m_en[i] = 1'b0; m_wave[i] = 1'b0;
            end
            act = 0; vdue = 0;
            e_phase = '0; e_wave = 1'b0; e_sample = '0; e_overrun = 1'b0;
            check("rst_phase", o_Phase, 0);
            check("rst_wave", o_Waveform, 0);
            check("rst_sample", o_Sample, 0);
            check("rst_valid", o_SampleValid, 0);
            check("rst_busy", o_Busy, 0);
            check("rst_overrun", o_Overrun, 0);
        end else begin
            busy = act && (cyc >= n0 + 1) && (cyc <= n0 + 36);
            if (act && (cyc >= n0 + 2) && (cyc <= n0 + 33)) begin
                e_phase = f_ph[cyc - n0 - 2];
                e_wave  = f_wv[cyc - n0 - 2];
            end
            vld = vdue && (cyc == vcyc);
            if (vld) begin
                e_sample = vsample;
                vdue = 0;
            end
            check("busy", o_Busy, busy);
            check("valid", o_SampleValid, vld);
            check("sample", o_Sample, e_sample);
            check("phase", o_Phase, e_phase);
            check("wave", o_Waveform, e_wave);
            check("overrun", o_Overrun, e_overrun);

            if (i_ConfigWrite) begin
                m_inc[i_ConfigVoice]  = i_ConfigIncrement;
                m_en[i_ConfigVoice]   = i_ConfigEnable;
                m_wave[i_ConfigVoice] = i_ConfigWaveform;
                if (i_ConfigPhaseReset) m_acc[i_ConfigVoice] = '0;
            end
            if (i_SampleTick) begin
                if (busy) begin
                    e_overrun = 1'b1;
                end else begin
                    n0 = cyc;
                    act = 1;
                    sum = 0;
                    for (int v = 0; v < NV; v++) begin
                        f_ph[v] = m_acc[v][23:11];
                        f_wv[v] = m_wave[v];
                        if (m_en[v]) begin
                            sum += longint'($signed(gen_amp(f_ph[v], f_wv[v])));
                            m_acc[v] = m_acc[v] + m_inc[v];
                        end
                    end
                    sum = sum >>> 3;
                    if (sum > 32767) sum = 32767;
                    else if (sum < -32768) sum = -32768;
                    vsample = 16'(sum);
                    vdue = 1;
                    vcyc = cyc + 37;
                end
            end
        end
    end

    task automatic cfg(input int v, input logic [23:0] inc, input logic wv, input logic en, input logic pr);
        i_ConfigWrite      = 1'b1;
        i_ConfigVoice      = v[4:0];
        i_ConfigIncrement  = inc;
        i_ConfigWaveform   = wv;
        i_ConfigEnable     = en;
        i_ConfigPhaseReset = pr;
        @(posedge i_Clock); #1;
        i_ConfigWrite      = 1'b0;
        i_ConfigPhaseReset = 1'b0;
    endtask

    task automatic tick();
        i_SampleTick = 1'b1;
        @(posedge i_Clock); #1;
        i_SampleTick = 1'b0;
    endtask

    // exp_s < 0 skips the sample literal; pv < 0 skips the phase probe of voice pv.
    task automatic frame(input string name, input int exp_s, input int pv, input int exp_ph);
        int lat;
        tick();
        lat = 0;
        while (o_SampleValid !== 1'b1 && lat < 100) begin
            @(posedge i_Clock); #1;
            lat++;
            if (lat == pv + 1) check({name, "_phase"}, o_Phase, exp_ph[12:0]);
        end
        check({name, "_latency"}, lat, 36);
        if (exp_s >= 0) check(name, o_Sample, exp_s[15:0]);
        @(posedge i_Clock); #1;
    endtask

    initial begin
        int nvalid;
        repeat (3) @(posedge i_Clock);
        #1;
        check("init_sample", o_Sample, 0);
        check("init_busy", o_Busy, 0);
        i_Reset = 1'b0;
        @(posedge i_Clock); #1;

        cfg(0, 24'h0, 1'b1, 1'b1, 1'b0);
        frame("single_square", 'h0FFF, 0, 0);

        for (int v = 0; v < NV; v++) cfg(v, 24'h0, 1'b1, 1'b1, 1'b1);
        frame("sat_all_pos", 'h7FFF, -1, 0);
        for (int v = 0; v < NV; v++) cfg(v, 24'h800000, 1'b1, 1'b1, 1'b1);
        frame("sat_frame1", 'h7FFF, 31, 'h0000);
        frame("sat_frame2", 'h8000, 31, 'h1000);

        for (int v = 0; v < NV; v++) cfg(v, 24'h0, 1'b0, 1'b0, 1'b1);
        cfg(0, 24'h800000, 1'b1, 1'b1, 1'b1);
        frame("wrap1", 'h0FFF, 0, 'h0000);
        frame("wrap2", 'hF000, 0, 'h1000);
        frame("wrap3", 'h0FFF, 0, 'h0000);
        frame("wrap4", 'hF000, 0, 'h1000);

        cfg(0, 24'h0, 1'b1, 1'b0, 1'b1);
        cfg(5, 24'h000800, 1'b0, 1'b1, 1'b1);
        frame("adv0", 0, 5, 0);
        frame("adv1", 1, 5, 1);
        frame("adv2", 2, 5, 2);
        cfg(5, 24'h000800, 1'b0, 1'b0, 1'b0);
        frame("disabled1", 0, 5, 3);
        frame("disabled2", 0, 5, 3);

        check("ovr_before", o_Overrun, 0);
        tick();
        repeat (9) begin @(posedge i_Clock); #1; end
        tick();
        nvalid = 0;
        repeat (60) begin
            @(posedge i_Clock); #1;
            if (o_SampleValid === 1'b1) nvalid++;
        end
        check("ovr_flag", o_Overrun, 1);
        check("ovr_one_valid", nvalid, 1);

        cfg(7, 24'h000800, 1'b1, 1'b1, 1'b1);
        frame("col_pre", 'h0FFF, 7, 0);
        tick();
        repeat (7) begin @(posedge i_Clock); #1; end
        cfg(7, 24'h000800, 1'b1, 1'b1, 1'b1);
        check("col_old_phase", o_Phase, 1);
        nvalid = 0;
        while (o_SampleValid !== 1'b1 && nvalid < 100) begin @(posedge i_Clock); #1; nvalid++; end
        check("col_sample", o_Sample, 'h0FFF);
        @(posedge i_Clock); #1;
        frame("col_post", 'h0FFF, 7, 0);

        tick();
        repeat (4) begin @(posedge i_Clock); #1; end
        i_Reset = 1'b1;
        #1;
        check("mid_rst_busy", o_Busy, 0);
        check("mid_rst_sample", o_Sample, 0);
        check("mid_rst_overrun", o_Overrun, 0);
        check("mid_rst_phase", o_Phase, 0);
        repeat (2) @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        nvalid = 0;
        repeat (40) begin
            @(posedge i_Clock); #1;
            if (o_SampleValid === 1'b1) nvalid++;
        end
        check("mid_rst_no_valid", nvalid, 0);
        frame("post_rst", 0, 7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Time-multiplexes the single shared waveform generator across NUM_VOICES oscillator voices once per audio sample.
- Holds per-voice configuration: phase increment, waveform select and enable.
- Keeps a per-voice phase accumulator, issues one voice per clock to the generator, and collects the returned amplitudes.
- Mixes the amplitudes into one saturated 16-bit sample per frame, for the DAC/output stage downstream.

Parameters:
- NUM_VOICES, 32, voices per frame; power of two, 2..64.
- ACC_WIDTH, 24, phase accumulator width; generator phase = acc[ACC_WIDTH-1 -: 13].
- GEN_LATENCY, 3, clock cycles from phase/waveform in to amplitude out of the generator.
- MIX_SHIFT, 3, arithmetic right shift applied to the voice sum before saturation.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_SampleTick  in  1  one-cycle pulse; starts a frame.
- i_ConfigWrite  in  1  write strobe for the voice config table.
- i_ConfigVoice  in  log2(NUM_VOICES)  target voice index.
- i_ConfigIncrement  in  ACC_WIDTH  phase increment per frame.
- i_ConfigWaveform  in  1  0 = sine, 1 = square.
- i_ConfigEnable  in  1  voice enable.
- i_ConfigPhaseReset  in  1  with i_ConfigWrite, clears the target voice's accumulator.
- o_Phase  out  13  phase to the generator.
- o_Waveform  out  1  waveform select to the generator.
- i_Amplitude  in  16 signed  generator output.
- o_Sample  out  16 signed  mixed sample; held between frames.
- o_SampleValid  out  1  one-cycle pulse when o_Sample updates.
- o_Busy  out  1  high while the frame is not IDLE.
- o_Overrun  out  1  sticky; a tick arrived while busy.

Behaviour:
- Reset (async, any state, including mid-frame):
  - State goes to IDLE; the frame in progress is abandoned with no o_SampleValid.
  - All accumulators, increments, enables and waveforms are cleared to 0.
  - o_Phase, o_Waveform, o_Sample, o_SampleValid, o_Busy and o_Overrun are all 0.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: when i_SampleTick=1, go to ISSUE with voice counter v=0 and mix sum=0.
- ISSUE, one voice per cycle:
  - Drive o_Phase = acc[v] top 13 bits (value before the update) and o_Waveform = wave[v], registered.
  - If enable[v]=1, write acc[v] <= acc[v] + inc[v], wrapping modulo 2^ACC_WIDTH. Disabled voices hold their phase.
  - Push tag enable[v] into a GEN_LATENCY-deep valid pipeline.
  - After v = NUM_VOICES-1, go to DRAIN.
- Alignment: the amplitude for the phase presented on o_Phase at cycle t is sampled from i_Amplitude at cycle t+GEN_LATENCY.
  - If the tag is 1, add sign-extended i_Amplitude to the sum; if 0, add nothing.
  - Sum width is 16 + log2(NUM_VOICES) bits; it never overflows.
- DRAIN: lasts GEN_LATENCY cycles to collect the last voices, then go to DONE.
- DONE (1 cycle):
  - o_Sample <= saturate16(sum >>> MIX_SHIFT), clamped to [-32768, 32767].
  - Pulse o_SampleValid for this cycle, then go to IDLE.
- Frame length: NUM_VOICES + GEN_LATENCY + 1 cycles from the tick to o_SampleValid. o_Busy is high from the cycle after the tick through DONE.
- o_Phase/o_Waveform outside ISSUE: hold their last values. The generator free-runs and its output is ignored.
- i_SampleTick while o_Busy=1: the tick is ignored and o_Overrun is set; it clears only on reset. A tick in the DONE cycle is also an overrun.
- Config writes are accepted in any state and take effect the next cycle. A same-cycle ISSUE read of that voice uses the old values.
- Simultaneous ISSUE accumulator update and i_ConfigPhaseReset on the same voice: the reset wins, and acc becomes 0.
- With i_ConfigPhaseReset=0, a config write never touches the accumulator.

Test Plan:
- Single voice, square: voice0 enabled, inc=0, wave=1, others disabled; tick -> o_SampleValid exactly 36 cycles after the tick (defaults), o_Sample=0x0FFF (32767>>>3).
- Saturation: all 32 voices square, phase 0; tick -> o_Sample=0x7FFF. Then phase-reset all voices with inc=0x800000 and tick twice -> frame 1 0x7FFF, frame 2 0x8000.
- Wrap: voice0 only, square, inc=0x800000; four ticks -> o_Sample sequence 0x0FFF, 0xF000, 0x0FFF, 0xF000; o_Phase for voice0 alternates 0x0000/0x1000.
- Phase advance and disable: voice5 inc=0x000800 enabled -> its o_Phase is 0, 1, 2 on successive frames. Then disable it -> phase holds and its contribution is 0.
- Overrun and collision: tick again 10 cycles into a frame -> no restart, o_Overrun=1, one o_SampleValid. A config write with phase reset to voice v in its ISSUE cycle -> that frame uses the old phase, next frame o_Phase=0.
- Reset mid-frame: assert i_Reset during ISSUE -> all outputs 0 immediately, no o_SampleValid. After release, a tick gives a normal frame with all voices silent, so o_Sample=0.
